// File: rtl/bresenham_line_engine_if.sv
// Handshake and cell-stream bundle between the SLAM control unit / occupancy
// grid updater (master) and the Bresenham line engine (slave).
//   start, x0, y0, x1, y1 : ray request, sampled with start
//   busy                  : engine is working on a ray
//   cell_x, cell_y        : current line cell
//   cell_valid/cell_ready : valid/ready stream handshake
//   cell_endpoint         : current cell is the ray end (occupied cell)
interface bresenham_line_engine_if #(
  parameter int unsigned COORD_WIDTH = 10
) ();

  logic                   start;
  logic [COORD_WIDTH-1:0] x0;
  logic [COORD_WIDTH-1:0] y0;
  logic [COORD_WIDTH-1:0] x1;
  logic [COORD_WIDTH-1:0] y1;
  logic                   busy;
  logic [COORD_WIDTH-1:0] cell_x;
  logic [COORD_WIDTH-1:0] cell_y;
  logic                   cell_valid;
  logic                   cell_ready;
  logic                   cell_endpoint;

  modport master (
    output start, x0, y0, x1, y1, cell_ready,
    input  busy, cell_x, cell_y, cell_valid, cell_endpoint
  );

  modport slave (
    input  start, x0, y0, x1, y1, cell_ready,
    output busy, cell_x, cell_y, cell_valid, cell_endpoint
  );

endinterface

// File: rtl/bresenham_line_engine.sv
// Bresenham line engine: on start, latches a ray (x0,y0)->(x1,y1) and streams
// every grid cell of the line, both ends inclusive, over a valid/ready port.
// The final cell carries cell_endpoint=1.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of bresenham_line_engine_if (request, busy, cell stream)
module bresenham_line_engine #(
  parameter int unsigned COORD_WIDTH = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  bresenham_line_engine_if.slave   bus
);

  localparam int unsigned CW = COORD_WIDTH;
  localparam int unsigned DW = COORD_WIDTH + 1;
  localparam int unsigned EW = COORD_WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]        x0_q, x0_d, y0_q, y0_d;
  logic [CW-1:0]        x1_q, x1_d, y1_q, y1_d;
  logic signed [DW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [EW-1:0] err_q, err_d;
  logic [CW-1:0]        cell_x_q, cell_x_d, cell_y_q, cell_y_d;
  logic                 cell_valid_q, cell_valid_d;
  logic                 cell_endpoint_q, cell_endpoint_d;
  logic                 busy_q, busy_d;

  logic                 hs_c;
  logic signed [DW-1:0] diff_x_c, diff_y_c, abs_dx_c, neg_dy_c;
  logic signed [EW-1:0] e2_c, dx_ext_c, dy_ext_c;
  logic                 step_x_c, step_y_c;
  logic [CW-1:0]        next_x_c, next_y_c;

  assign hs_c = cell_valid_q & bus.cell_ready;

  // Setup arithmetic from the latched endpoints (zero-extended, then signed).
  assign diff_x_c = $signed(DW'(x1_q) - DW'(x0_q));
  assign diff_y_c = $signed(DW'(y1_q) - DW'(y0_q));
  assign abs_dx_c = diff_x_c[DW-1] ? -diff_x_c : diff_x_c;
  assign neg_dy_c = diff_y_c[DW-1] ? diff_y_c : -diff_y_c;

  // Step decision; size casts of signed values sign-extend.
  assign dx_ext_c = EW'(dx_q);
  assign dy_ext_c = EW'(dy_q);
  assign e2_c     = err_q <<< 1;
  assign step_x_c = (e2_c >= dy_ext_c);
  assign step_y_c = (e2_c <= dx_ext_c);

  always_comb begin
    next_x_c = cell_x_q;
    next_y_c = cell_y_q;
    if (step_x_c) next_x_c = sx_neg_q ? cell_x_q - CW'(1) : cell_x_q + CW'(1);
    if (step_y_c) next_y_c = sy_neg_q ? cell_y_q - CW'(1) : cell_y_q + CW'(1);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SETUP;
      SETUP:   state_d = EMIT;
      EMIT:    if (hs_c && cell_endpoint_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; outputs are set up one cycle ahead.
  always_comb begin
    x0_d            = x0_q;
    y0_d            = y0_q;
    x1_d            = x1_q;
    y1_d            = y1_q;
    dx_d            = dx_q;
    dy_d            = dy_q;
    sx_neg_d        = sx_neg_q;
    sy_neg_d        = sy_neg_q;
    err_d           = err_q;
    cell_x_d        = cell_x_q;
    cell_y_d        = cell_y_q;
    cell_valid_d    = cell_valid_q;
    cell_endpoint_d = cell_endpoint_q;
    busy_d          = busy_q;
    case (state_q)
      IDLE: begin
        busy_d       = 1'b0;
        cell_valid_d = 1'b0;
        if (bus.start) begin
          x0_d   = bus.x0;
          y0_d   = bus.y0;
          x1_d   = bus.x1;
          y1_d   = bus.y1;
          busy_d = 1'b1;
        end
      end
      SETUP: begin
        dx_d            = abs_dx_c;
        dy_d            = neg_dy_c;
        sx_neg_d        = !(x0_q < x1_q);
        sy_neg_d        = !(y0_q < y1_q);
        err_d           = EW'(abs_dx_c) + EW'(neg_dy_c);
        cell_x_d        = x0_q;
        cell_y_d        = y0_q;
        cell_endpoint_d = (x0_q == x1_q) && (y0_q == y1_q);
        cell_valid_d    = 1'b1;
        busy_d          = 1'b1;
      end
      EMIT: begin
        if (hs_c) begin
          if (cell_endpoint_q) begin
            busy_d          = 1'b0;
            cell_valid_d    = 1'b0;
            cell_endpoint_d = 1'b0;
          end else begin
            err_d           = err_q + (step_x_c ? dy_ext_c : '0)
                                    + (step_y_c ? dx_ext_c : '0);
            cell_x_d        = next_x_c;
            cell_y_d        = next_y_c;
            cell_endpoint_d = (next_x_c == x1_q) && (next_y_c == y1_q);
          end
        end
      end
      default: begin
        busy_d       = 1'b0;
        cell_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      x0_q            <= '0;
      y0_q            <= '0;
      x1_q            <= '0;
      y1_q            <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      sx_neg_q        <= 1'b0;
      sy_neg_q        <= 1'b0;
      err_q           <= '0;
      cell_x_q        <= '0;
      cell_y_q        <= '0;
      cell_valid_q    <= 1'b0;
      cell_endpoint_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      x0_q            <= x0_d;
      y0_q            <= y0_d;
      x1_q            <= x1_d;
      y1_q            <= y1_d;
      dx_q            <= dx_d;
      dy_q            <= dy_d;
      sx_neg_q        <= sx_neg_d;
      sy_neg_q        <= sy_neg_d;
      err_q           <= err_d;
      cell_x_q        <= cell_x_d;
      cell_y_q        <= cell_y_d;
      cell_valid_q    <= cell_valid_d;
      cell_endpoint_q <= cell_endpoint_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.cell_x        = cell_x_q;
  assign bus.cell_y        = cell_y_q;
  assign bus.cell_valid    = cell_valid_q;
  assign bus.cell_endpoint = cell_endpoint_q;

endmodule
